// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the write-through data cache.
package dcache_pkg;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned OFF_W      = 2;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE
  } state_e;

  function automatic int unsigned idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  // Byte offset (2) + word offset + index, the rest is tag.
  function automatic int unsigned tag_w(input int unsigned lines);
    return 32 - 2 - OFF_W - idx_w(lines);
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Data/tag/valid storage for the direct-mapped cache: async read, sync writes.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  localparam int unsigned IDX_W = idx_w(LINES),
  localparam int unsigned TAG_W = tag_w(LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [OFF_W-1:0] rd_offset,
  output logic [31:0]      rd_data,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [OFF_W-1:0] wr_offset,
  input  logic [3:0]       wr_be,
  input  logic [31:0]      wr_data,
  input  logic             tv_we,
  input  logic [IDX_W-1:0] tv_index,
  input  logic [TAG_W-1:0] tv_tag,
  input  logic             tv_valid
);

  logic [31:0]      data_q [LINES][LINE_WORDS];
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LINES-1:0] valid_q;

  assign rd_data  = data_q[rd_index][rd_offset];
  assign rd_tag   = tag_q[rd_index];
  assign rd_valid = valid_q[rd_index];

  // Per-byte word write; data array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) data_q[wr_index][wr_offset][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tv_we) tag_q[tv_index] <= tv_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (tv_we) begin
      valid_q[tv_index] <= tv_valid;
    end
  end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache for the MEM stage.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byte_en,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned IDX_W = idx_w(LINES);
  localparam int unsigned TAG_W = tag_w(LINES);
  localparam int unsigned WC_W  = $clog2(WORDS_PER_LINE);

  state_e            state_q, state_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [OFF_W-1:0]  off;
  logic [31:0]       rd_data;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic              hit;
  logic              wr_en;
  logic [OFF_W-1:0]  wr_off;
  logic [31:0]       wr_data;
  logic [3:0]        wr_be;
  logic              tv_we;
  logic              tv_valid;
  logic              load_hit;
  logic              load_miss;
  logic              unused_addr;

  assign idx         = cpu_addr[4 +: IDX_W];
  assign tag         = cpu_addr[31 -: TAG_W];
  assign off         = cpu_addr[3:2];
  assign hit         = rd_valid && (rd_tag == tag);
  assign cpu_rdata   = rd_data;
  assign unused_addr = ^cpu_addr[1:0];

  dcache_line_store #(
    .LINES(LINES)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_index (idx),
    .rd_offset(off),
    .rd_data  (rd_data),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_index (idx),
    .wr_offset(wr_off),
    .wr_be    (wr_be),
    .wr_data  (wr_data),
    .tv_we    (tv_we),
    .tv_index (idx),
    .tv_tag   (tag),
    .tv_valid (tv_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Next state, array write controls and memory-side handshake.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    cpu_stall  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    wr_en      = 1'b0;
    wr_off     = off;
    wr_data    = cpu_wdata;
    wr_be      = cpu_byte_en;
    tv_we      = 1'b0;
    tv_valid   = 1'b0;
    load_hit   = 1'b0;
    load_miss  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            cpu_stall = 1'b1;
            state_d   = WRITE;
          end else if (hit) begin
            load_hit = 1'b1;
          end else begin
            // Invalidate up front so an interrupted refill never looks valid.
            cpu_stall  = 1'b1;
            load_miss  = 1'b1;
            tv_we      = 1'b1;
            tv_valid   = 1'b0;
            word_cnt_d = '0;
            state_d    = REFILL;
          end
        end
      end

      REFILL: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {tag, idx, word_cnt_q, 2'b00};
        if (mem_ready) begin
          wr_en      = 1'b1;
          wr_off     = OFF_W'(word_cnt_q);
          wr_data    = mem_rdata;
          wr_be      = 4'hF;
          word_cnt_d = word_cnt_q + WC_W'(1);
          if (word_cnt_q == WC_W'(WORDS_PER_LINE - 1)) begin
            tv_we    = 1'b1;
            tv_valid = 1'b1;
            state_d  = IDLE;
          end
        end
      end

      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {cpu_addr[31:2], 2'b00};
        mem_wdata = cpu_wdata;
        mem_be    = cpu_byte_en;
        cpu_stall = ~mem_ready;
        if (mem_ready) begin
          wr_en   = hit;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (load_hit)  hit_q  <= hit_q + 32'd1;
      if (load_miss) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  logic unused_stats;

  assign unused_stats = load_hit ^ load_miss;
  assign hit_cnt      = '0;
  assign miss_cnt     = '0;
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt with a behavioural word memory and wait-state control.
module tb_dcache_wt;

`ifdef DCACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_byte_en;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  dcache_wt dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_byte_en(cpu_byte_en),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [1024];
  int          mem_wait = 0;
  int          stable_err = 0;
  int          idle_err = 0;
  logic [31:0] log_addr [$];
  logic [3:0]  log_be [$];
  logic        log_we [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory responder: decides mem_ready for the coming edge on each falling edge.
  initial begin
    int          wcnt;
    bit          prev_wait;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;
    logic        last_we;
    logic [9:0]  widx;
    wcnt      = 0;
    prev_wait = 1'b0;
    last_addr = '0; last_wdata = '0; last_be = '0; last_we = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i * 4);
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (prev_wait && (mem_addr !== last_addr || mem_we !== last_we ||
                          mem_wdata !== last_wdata || mem_be !== last_be))
          stable_err++;
        if (wcnt >= mem_wait) begin
          mem_ready = 1'b1;
          widx = mem_addr[11:2];
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) mem[widx][8*b +: 8] = mem_wdata[8*b +: 8];
          end else begin
            mem_rdata = mem[widx];
          end
          log_addr.push_back(mem_addr);
          log_be.push_back(mem_be);
          log_we.push_back(mem_we);
          wcnt = 0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 32'hDEAD_BEEF;
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wcnt = 0;
        if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_be !== 4'd0 || mem_we !== 1'b0)
          idle_err++;
      end
      prev_wait  = mem_req && !mem_ready;
      last_addr  = mem_addr;
      last_wdata = mem_wdata;
      last_be    = mem_be;
      last_we    = mem_we;
    end
  end

  task automatic do_load(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_data, input int exp_stall);
    int n;
    n = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr; cpu_wdata = '0; cpu_byte_en = '0;
    #1;
    while (cpu_stall && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, "_stall"}, 32'(n), 32'(exp_stall));
    check({tag, "_data"}, cpu_rdata, exp_data);
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input int exp_stall);
    int n;
    n = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = addr; cpu_wdata = data; cpu_byte_en = be;
    #1;
    while (cpu_stall && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, "_stall"}, 32'(n), 32'(exp_stall));
  endtask

  task automatic idle();
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
  endtask

  task automatic check_cnt(input string tag, input int exp_hit, input int exp_miss);
    check({tag, "_hit_cnt"},  hit_cnt,  STATS ? 32'(exp_hit)  : 32'd0);
    check({tag, "_miss_cnt"}, miss_cnt, STATS ? 32'(exp_miss) : 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_byte_en = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check_cnt("rst", 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // Cold load miss, zero-wait refill
    base = log_addr.size();
    do_load("t1", 32'h100, 32'h1000_0100, 5);
    check("t1_xfers", 32'(log_addr.size() - base), 32'd4);
    for (int k = 0; k < 4; k++)
      if (log_addr.size() > base + k)
        check($sformatf("t1_addr%0d", k), log_addr[base + k], 32'h100 + 32'(4 * k));

    // Back-to-back hit on the refilled line
    base = log_addr.size();
    do_load("t2", 32'h108, 32'h1000_0108, 0);
    check("t2_no_xfer", 32'(log_addr.size() - base), 32'd0);
    idle();
    check_cnt("t2", 2, 1);

    // Partial store hit, then reload merged word from cache
    base = log_addr.size();
    do_store("t3", 32'h104, 32'hAABB_CCDD, 4'b0011, 1);
    check("t3_xfers", 32'(log_addr.size() - base), 32'd1);
    if (log_addr.size() > base) begin
      check("t3_waddr", log_addr[base], 32'h104);
      check("t3_we", 32'(log_we[base]), 32'd1);
      check("t3_be", 32'(log_be[base]), 32'h3);
    end
    base = log_addr.size();
    do_load("t3ld", 32'h104, 32'h1000_CCDD, 0);
    check("t3ld_no_xfer", 32'(log_addr.size() - base), 32'd0);

    // Store miss does not allocate
    do_store("t4", 32'h200, 32'h1122_3344, 4'hF, 1);
    base = log_addr.size();
    do_load("t4ld", 32'h200, 32'h1122_3344, 5);
    check("t4ld_xfers", 32'(log_addr.size() - base), 32'd4);

    // Three wait states per word
    idle();
    mem_wait = 3;
    base = log_addr.size();
    do_load("t5", 32'h300, 32'h1000_0300, 17);
    if (log_addr.size() > base + 3) check("t5_last_addr", log_addr[base + 3], 32'h30C);
    idle();
    mem_wait = 0;
    check_cnt("t5", 5, 3);

    // Reset during the third refill word
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h400;
    repeat (3) @(negedge clk);
    rst = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    #1;
    check("t6_mem_req", 32'(mem_req), 32'd0);
    check("t6_stall", 32'(cpu_stall), 32'd0);
    check("t6_mem_addr", mem_addr, 32'd0);
    check_cnt("t6_rst", 0, 0);
    rst = 1'b1;
    base = log_addr.size();
    do_load("t6ld", 32'h400, 32'h1000_0400, 5);
    check("t6ld_xfers", 32'(log_addr.size() - base), 32'd4);
    idle();
    check_cnt("t6", 1, 1);

    check("addr_stable", 32'(stable_err), 32'd0);
    check("idle_bus_zero", 32'(idle_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
